// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, transmit-queue depth and queue FSM states.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package uart_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int UART_TXQ_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_txq_mem.sv
// Byte storage for the transmit queue: DEPTH x 8 register array with a registered read port.
// Latency: write lands on the clock edge; read data appears one edge after rdEn.
// Backpressure: none, the caller guarantees writes only when not full and reads only when not empty.
module uart_txq_mem
  import uart_pkg::*;
#(
  parameter int  DEPTH = UART_TXQ_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wrEn,
  input  logic [AW-1:0]          wrAddr,
  input  logic [UART_BYTE_W-1:0] wrData,
  input  logic                   rdEn,
  input  logic [AW-1:0]          rdAddr,
  output logic [UART_BYTE_W-1:0] rdData
);

  logic [UART_BYTE_W-1:0] mem [DEPTH];

  // The array itself needs no reset: emptiness is tracked by the pointers upstream.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdData <= '0;
    else if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/uart_tx_queue.sv
// CPU-to-rs232tx byte queue; optional sticky overrun flag under UART_TXQ_OVERRUN_EN.
// Latency: a push into an empty queue with idle serializer gives tx_start two cycles later.
// Backpressure: pushes while full are dropped; pops wait for ~tx_busy and a full busy cycle.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [UART_BYTE_W-1:0]  wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    tx_start,
  output logic [UART_BYTE_W-1:0]  tx_data,
  input  logic                    tx_busy
`ifdef UART_TXQ_OVERRUN_EN
  ,
  output logic                    overrun,
  input  logic                    overrun_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  txq_state_t    state;
  logic          push;
  logic          pop;

  assign full  = (cnt == FULL_LVL);
  assign empty = (cnt == '0);
  assign level = cnt;

  // full is taken from the registered count, so a push beside a pop at DEPTH is still dropped.
  assign push = wr_en & ~full;
  assign pop  = (state == IDLE) & ~empty & ~tx_busy;

  uart_txq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (push),
    .wrAddr (wp),
    .wrData (wr_data),
    .rdEn   (pop),
    .rdAddr (rp),
    .rdData (tx_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Waiting for busy to rise before watching it fall keeps one start per serializer frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= LAUNCH;
            tx_start <= 1'b1;
          end
        end
        LAUNCH:    state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               overrun <= 1'b0;
    else if (wr_en & full)    overrun <= 1'b1;
    else if (overrun_clr)     overrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: rs232tx model plus a scoreboard of bytes expected on tx_start.
// Stimulus and level checks run in one process; the monitor pops and compares on each tx_start.
module tb_uart_tx_queue;

  localparam int BUSY_N = 20;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
`ifdef UART_TXQ_OVERRUN_EN
  logic       overrun;
  logic       overrun_clr;
`endif

  logic       modelBusy;
  logic       extBusy;
  logic       prevStart;
  logic [7:0] expQ[$];
  int         passCnt;
  int         totalCnt;

  assign tx_busy = modelBusy | extBusy;

  uart_tx_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
`ifdef UART_TXQ_OVERRUN_EN
    ,
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // rs232tx model: busy rises one cycle after start is seen and holds for BUSY_N cycles.
  initial begin
    modelBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(negedge clk);
        modelBusy = 1'b1;
        repeat (BUSY_N) @(negedge clk);
        modelBusy = 1'b0;
      end
    end
  end

  // Monitor: every tx_start must carry the next expected byte, be one cycle wide and find busy low.
  initial prevStart = 1'b0;
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      check("start_while_busy", {31'd0, tx_busy}, 32'd0);
      check("start_pulse_width", {31'd0, prevStart}, 32'd0);
      check("sb_has_entry", {31'd0, (expQ.size() > 0)}, 32'd1);
      if (expQ.size() > 0) check("tx_data_order", {24'd0, tx_data}, {24'd0, expQ.pop_front()});
    end
    prevStart = tx_start;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pushByte(input logic [7:0] b, input bit accepted);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted) expQ.push_back(b);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      if (empty && !tx_busy) stable++;
      else stable = 0;
    end
    check({name, "_drained"}, {31'd0, (stable >= 4)}, 32'd1);
    check({name, "_sb_empty"}, expQ.size(), 32'd0);
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    extBusy  = 1'b0;
`ifdef UART_TXQ_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_full",  {31'd0, full},     32'd0);
    check("rst_empty", {31'd0, empty},    32'd1);
    check("rst_level", {27'd0, level},    32'd0);
    check("rst_start", {31'd0, tx_start}, 32'd0);
    check("rst_data",  {24'd0, tx_data},  32'd0);
`ifdef UART_TXQ_OVERRUN_EN
    check("rst_overrun", {31'd0, overrun}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte, latency and level return to zero
    pushByte(8'hA5, 1'b1);
    check("t1_level_after_push", {27'd0, level}, 32'd1);
    check("t1_not_empty",        {31'd0, empty}, 32'd0);
    check("t1_no_start_yet",     {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    check("t1_start_latency", {31'd0, tx_start}, 32'd1);
    check("t1_level_popped",  {27'd0, level},    32'd0);
    check("t1_empty_again",   {31'd0, empty},    32'd1);
    @(negedge clk);
    check("t1_start_dropped", {31'd0, tx_start}, 32'd0);
    waitDrain("t1");

    // 2: fill to DEPTH while the serializer is held busy
    extBusy = 1'b1;
    for (int i = 0; i < 16; i++) pushByte(i[7:0], 1'b1);
    check("t2_full",      {31'd0, full},  32'd1);
    check("t2_level_16",  {27'd0, level}, 32'd16);
    check("t2_not_empty", {31'd0, empty}, 32'd0);

    // 3: push while full is dropped
`ifdef UART_TXQ_OVERRUN_EN
    check("t3_overrun_before", {31'd0, overrun}, 32'd0);
`endif
    pushByte(8'hFF, 1'b0);
    check("t3_level_held", {27'd0, level}, 32'd16);
    check("t3_still_full", {31'd0, full},  32'd1);
`ifdef UART_TXQ_OVERRUN_EN
    check("t3_overrun_set", {31'd0, overrun}, 32'd1);
    repeat (2) @(negedge clk);
    check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("t3_overrun_cleared", {31'd0, overrun}, 32'd0);
`endif
    extBusy = 1'b0;
    waitDrain("t2_t3");

    // 4: push on the same edge as the IDLE->LAUNCH pop at level 3
    extBusy = 1'b1;
    pushByte(8'h40, 1'b1);
    pushByte(8'h41, 1'b1);
    pushByte(8'h42, 1'b1);
    check("t4_level_3", {27'd0, level}, 32'd3);
    extBusy = 1'b0;
    pushByte(8'h43, 1'b1);
    check("t4_level_kept", {27'd0, level},    32'd3);
    check("t4_launched",   {31'd0, tx_start}, 32'd1);
    waitDrain("t4");

    // 5: external busy holds off every launch
    extBusy = 1'b1;
    pushByte(8'h50, 1'b1);
    pushByte(8'h51, 1'b1);
    pushByte(8'h52, 1'b1);
    repeat (10) @(negedge clk);
    check("t5_level_held", {27'd0, level}, 32'd3);
    extBusy = 1'b0;
    waitDrain("t5");

    // 6: reset in WAIT_DONE with five bytes queued
    for (int i = 0; i < 6; i++) pushByte(8'h60 + i[7:0], 1'b1);
    repeat (4) @(negedge clk);
    check("t6_level_5",   {27'd0, level},   32'd5);
    check("t6_busy_high", {31'd0, tx_busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_full",  {31'd0, full},     32'd0);
    check("t6_rst_empty", {31'd0, empty},    32'd1);
    check("t6_rst_level", {27'd0, level},    32'd0);
    check("t6_rst_start", {31'd0, tx_start}, 32'd0);
    check("t6_rst_data",  {24'd0, tx_data},  32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pushByte(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_busy_still_high", {31'd0, tx_busy}, 32'd1);
    check("t6_waiting_level",   {27'd0, level},   32'd1);
    waitDrain("t6");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
